lcd_spi_write: RTL
==================

LCD_SPI_WRITE -- requirements
Module: lcd_spi_write

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 2, sys_clk cycles per SCLK half-period (legal 1..255; 0 SHALL cause an elaboration error).
REQ-002 sys_clk  input  1  sole clock; all logic on the rising edge.
REQ-003 sys_rst  input  1  reset, synchronous, active-high.
REQ-004 data  input  9  [8]=D/C (1 data, 0 command), [7:0] byte to send MSB-first.
REQ-005 en_write  input  1  level request; byte in data is valid while high.
REQ-006 wr_done  output  1  one-cycle pulse: current byte fully shifted.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 lcd_cs  output  1  LCD chip select, active-low.
REQ-009 lcd_dc  output  1  LCD D/C line.
REQ-010 lcd_sclk  output  1  SPI clock, mode 0 (idle low, sampled on rising edge).
REQ-011 lcd_mosi  output  1  SPI data.

Function
REQ-012 SHALL implement states IDLE, SHIFT, HOLD, DONE, GUARD; transitions only as below.
REQ-013 IDLE: on an edge with en_write=1 (cycle 0), SHALL latch data into a 9-bit shift register and enter SHIFT.
REQ-014 SHIFT, cycles 1..16*CLK_DIV: per bit, sclk low CLK_DIV cycles then high CLK_DIV cycles; mosi SHALL change only at the start of a low phase; lcd_cs=0; lcd_dc = latched data[8].
REQ-015 HOLD, cycles 16*CLK_DIV+1..17*CLK_DIV: sclk=0, mosi holds bit 0.
REQ-016 DONE, cycle 17*CLK_DIV+1: wr_done=1 for exactly this cycle.
REQ-017 GUARD, the next 2 cycles: no sampling of en_write (upstream needs 2 cycles to present its next byte after wr_done); then IDLE.
REQ-018 With CLK_DIV=2: wr_done at cycle 35; earliest next acceptance at cycle 38.
REQ-019 en_write falling mid-byte SHALL NOT abort; the byte completes and wr_done still pulses.
REQ-020 data changing after cycle 0 SHALL NOT affect the byte in flight.
REQ-021 en_write high continuously SHALL stream bytes back-to-back at 17*CLK_DIV+4 cycles per byte.
REQ-022 Half-period counter SHALL be ceil(log2(CLK_DIV+1)) bits and reload at each phase end; bit counter 3 bits, leaving SHIFT when it wraps 7->0 at the end of a high phase.
REQ-023 wr_done SHALL never be asserted outside DONE.

Reset
REQ-024 sys_rst=1 SHALL, on the next edge, force IDLE and lcd_cs=1, lcd_sclk=0, lcd_mosi=0, lcd_dc=0, wr_done=0, busy=0, and clear all counters and the shift register.
REQ-025 Reset mid-byte SHALL discard the byte with no wr_done; the first edge after release with en_write=1 SHALL behave as cycle 0.

Configuration
REQ-026 Macro LCD_SPI_CS_TOGGLE_EN defined: lcd_cs SHALL rise at HOLD entry and stay high through DONE, GUARD and IDLE (one CS frame per byte).
REQ-027 Macro absent: lcd_cs SHALL stay low from first SHIFT through HOLD/DONE/GUARD and rise only in IDLE with en_write=0; all other timing unchanged.

Structure
REQ-028 Shared package lcd_pkg SHALL hold the state encoding, the RGB565 colour constants (WHITE, BLACK, RED, ...) used by upstream drawing blocks, and the CLK_DIV default.
REQ-029 One sub-module, lcd_spi_tick, SHALL generate the phase-end tick from CLK_DIV; everything else stays in lcd_spi_write.

Verification
REQ-030 CLK_DIV=2, data=9'h1F8, en_write one cycle high -> mosi 1,1,1,1,1,0,0,0 on rising sclk; lcd_dc=1; wr_done single pulse at cycle 35.
REQ-031 en_write held high, data=9'h0A5 then 9'h15A presented 2 cycles after wr_done -> command byte A5, data byte 5A; second acceptance at cycle 38; exactly 2 wr_done pulses.
REQ-032 sys_rst asserted at cycle 10 of a byte -> next edge: cs=1, sclk=0, busy=0; no wr_done; next byte after release sent intact.
REQ-033 en_write dropped at cycle 5, data changed at cycle 6 -> original byte sent unchanged, wr_done at cycle 35.
REQ-034 Two streamed bytes, with vs without LCD_SPI_CS_TOGGLE_EN -> cs pulses high between bytes vs stays low until en_write=0 in IDLE.
REQ-035 CLK_DIV=1 and CLK_DIV=255 -> wr_done at cycle 18 and 4336 respectively; sclk duty exactly 50%.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD definitions: SPI writer state encoding, default SCLK divider,
// the 9-bit D/C + byte word layout and RGB565 colours for drawing blocks.
package lcd_pkg;

    localparam int unsigned LCD_CLK_DIV_DEFAULT = 2;
    localparam int unsigned LCD_BYTE_W          = 8;
    localparam int unsigned LCD_BIT_CNT_W       = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DONE  = 3'd3,
        ST_GUARD = 3'd4
    } lcd_state_e;

    // D/C flag (1 = data, 0 = command) above the byte sent MSB-first
    typedef struct packed {
        logic                  dc;
        logic [LCD_BYTE_W-1:0] payload;
    } lcd_word_t;

    typedef logic [15:0] rgb565_t;

    localparam rgb565_t WHITE   = 16'hFFFF;
    localparam rgb565_t BLACK   = 16'h0000;
    localparam rgb565_t RED     = 16'hF800;
    localparam rgb565_t GREEN   = 16'h07E0;
    localparam rgb565_t BLUE    = 16'h001F;
    localparam rgb565_t YELLOW  = 16'hFFE0;
    localparam rgb565_t CYAN    = 16'h07FF;
    localparam rgb565_t MAGENTA = 16'hF81F;
    localparam rgb565_t GRAY    = 16'h8410;

    function automatic lcd_word_t lcd_cmd(input logic [LCD_BYTE_W-1:0] b);
        lcd_word_t w;
        w.dc      = 1'b0;
        w.payload = b;
        return w;
    endfunction

    function automatic lcd_word_t lcd_dat(input logic [LCD_BYTE_W-1:0] b);
        lcd_word_t w;
        w.dc      = 1'b1;
        w.payload = b;
        return w;
    endfunction

endpackage

// File: rtl/lcd_spi_tick.sv
// Half-period timer: pulses tick_c on the last sys_clk cycle of every SCLK phase
// while run_i is high; restarts from zero at each phase end or when idle.
module lcd_spi_tick
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_DIV = LCD_CLK_DIV_DEFAULT
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic run_i,
    output logic tick_c
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (run_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_c = run_i && (cnt_q == LAST);

endmodule

// File: rtl/lcd_spi_write.sv
// SPI mode-0 byte writer for a D/C-line LCD controller.
// Optional macro LCD_SPI_CS_TOGGLE_EN: deassert chip select after every byte.
module lcd_spi_write
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_DIV = LCD_CLK_DIV_DEFAULT
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [8:0] data,
    input  logic       en_write,
    output logic       wr_done,
    output logic       busy,
    output logic       lcd_cs,
    output logic       lcd_dc,
    output logic       lcd_sclk,
    output logic       lcd_mosi
);

    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("lcd_spi_write: CLK_DIV must be in 1..255");
    end

    lcd_state_e               state_q;
    lcd_state_e               state_d;
    lcd_word_t                shreg_q;
    lcd_word_t                shreg_d;
    logic [LCD_BIT_CNT_W-1:0] bit_q;
    logic [LCD_BIT_CNT_W-1:0] bit_d;
    logic                     phase_q;
    logic                     phase_d;
    logic                     guard_q;
    logic                     guard_d;

    logic wr_done_q, wr_done_d;
    logic busy_q,    busy_d;
    logic cs_q,      cs_d;
    logic dc_q,      dc_d;
    logic sclk_q,    sclk_d;
    logic mosi_q,    mosi_d;

    logic run;
    logic tick_c;

    assign run = (state_q == ST_SHIFT) || (state_q == ST_HOLD);

    lcd_spi_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .run_i   (run),
        .tick_c  (tick_c)
    );

    // State register; all outputs are registered from the next-state values
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_q     <= '0;
            phase_q   <= 1'b0;
            guard_q   <= 1'b0;
            wr_done_q <= 1'b0;
            busy_q    <= 1'b0;
            cs_q      <= 1'b1;
            dc_q      <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_q     <= bit_d;
            phase_q   <= phase_d;
            guard_q   <= guard_d;
            wr_done_q <= wr_done_d;
            busy_q    <= busy_d;
            cs_q      <= cs_d;
            dc_q      <= dc_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

    // Next state: phase flips on every tick; a bit retires at the end of its high phase
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        guard_d = guard_q;
        unique case (state_q)
            ST_IDLE: begin
                if (en_write) begin
                    state_d = ST_SHIFT;
                    shreg_d = lcd_word_t'(data);
                    bit_d   = '0;
                    phase_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (tick_c) begin
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        bit_d = bit_q + LCD_BIT_CNT_W'(1);
                        if (bit_q == LCD_BIT_CNT_W'(7)) begin
                            state_d = ST_HOLD;
                        end else begin
                            shreg_d.payload = {shreg_q.payload[LCD_BYTE_W-2:0], 1'b0};
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (tick_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_GUARD;
                guard_d = 1'b0;
            end
            ST_GUARD: begin
                guard_d = 1'b1;
                if (guard_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode; the last bit stays on mosi because it is never shifted out
    always_comb begin
        wr_done_d = (state_d == ST_DONE);
        busy_d    = (state_d != ST_IDLE);
        sclk_d    = (state_d == ST_SHIFT) && phase_d;
        mosi_d    = shreg_d.payload[LCD_BYTE_W-1];
        dc_d      = shreg_d.dc;
`ifdef LCD_SPI_CS_TOGGLE_EN
        cs_d      = (state_d != ST_SHIFT);
`else
        cs_d      = cs_q;
        if (state_d == ST_SHIFT) begin
            cs_d = 1'b0;
        end else if ((state_q == ST_IDLE) && !en_write) begin
            cs_d = 1'b1;
        end
`endif
    end

    assign wr_done  = wr_done_q;
    assign busy     = busy_q;
    assign lcd_cs   = cs_q;
    assign lcd_dc   = dc_q;
    assign lcd_sclk = sclk_q;
    assign lcd_mosi = mosi_q;

endmodule
